// File: rtl/wb_pipeline_checker.sv
// wb_pipeline_checker: passive Wishbone B4 pipelined-mode protocol checker.
// It records sticky violation flags, captures the first error, counts outstanding requests and counts completed bus cycles.
`default_nettype none

module wb_pipeline_checker #(
  parameter int DATA_W          = 32,
  parameter int ADR_W           = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT         = 255,
  localparam int SEL_W          = DATA_W / 8,
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CYC_O,
  input  logic              STB_O,
  input  logic              WE_O,
  input  logic [ADR_W-1:0]  ADR_O,
  input  logic [SEL_W-1:0]  SEL_O,
  input  logic [DATA_W-1:0] DAT_O,
  input  logic              STALL_I,
  input  logic              ACK_I,
  input  logic              ERR_I,
  input  logic              clear,
  output logic [7:0]        viol_flags,
  output logic              viol_pulse,
  output logic              first_valid,
  output logic [2:0]        first_code,
  output logic [CW-1:0]     outstanding,
  output logic [15:0]       xact_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_PRE = TW'(TIMEOUT - 1);

  logic [CW-1:0]     out_q, out_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [7:0]        flags_q, flags_d;
  logic              pulse_q;
  logic              fv_q, fv_d;
  logic [2:0]        fc_q, fc_d;
  logic [15:0]       xact_q, xact_d;
  logic              err_seen_q, err_seen_d;
  logic              prev_valid_q, prev_cyc_q, prev_stb_q, prev_we_q, prev_stalled_q;
  logic [ADR_W-1:0]  prev_adr_q;
  logic [SEL_W-1:0]  prev_sel_q;
  logic [DATA_W-1:0] prev_dat_q;

  logic       accept, resp, stalled, changed, tmo_inc;
  logic [7:0] det;
  logic [2:0] low_idx;

  always_comb begin
    accept  = CYC_O & STB_O & ~STALL_I;
    resp    = CYC_O & (ACK_I | ERR_I);
    stalled = CYC_O & STB_O & STALL_I;
    changed = (STB_O != prev_stb_q) | (ADR_O != prev_adr_q) | (SEL_O != prev_sel_q) |
              (WE_O != prev_we_q) | (prev_we_q & (DAT_O != prev_dat_q));
    tmo_inc = CYC_O & (out_q != '0) & ~resp;

    det    = '0;
    det[0] = STB_O & ~CYC_O;
    det[1] = prev_valid_q & prev_stalled_q & changed;
    det[2] = STB_O & WE_O & (SEL_O == '0);
    det[3] = prev_valid_q & (((ACK_I | ERR_I) & ~prev_cyc_q) | (resp & (out_q == '0)));
    det[4] = ACK_I & ERR_I;
    det[5] = prev_valid_q & prev_cyc_q & ~CYC_O & (out_q != '0) & ~err_seen_q;
    det[6] = accept & ~resp & (out_q == MAX_OUT);
    det[7] = tmo_inc & ~clear & (tmo_q == TMO_PRE);

    low_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (det[i]) low_idx = 3'(i);
    end

    out_d = out_q;
    if (!CYC_O) out_d = '0;
    else if (accept && !resp && out_q != MAX_OUT) out_d = out_q + CW'(1);
    else if (resp && !accept && out_q != '0) out_d = out_q - CW'(1);

    tmo_d = tmo_q;
    if (clear || !CYC_O || resp) tmo_d = '0;
    else if (tmo_inc && tmo_q != TMO_MAX) tmo_d = tmo_q + TW'(1);

    // A clear drops old history but still keeps whatever is detected this cycle
    flags_d = (clear ? 8'h00 : flags_q) | det;
    fv_d    = fv_q;
    fc_d    = fc_q;
    if (clear) begin
      fv_d = |det;
      fc_d = low_idx;
    end else if (!fv_q && |det) begin
      fv_d = 1'b1;
      fc_d = low_idx;
    end

    err_seen_d = CYC_O & (err_seen_q | ERR_I);
    xact_d     = xact_q;
    if (prev_cyc_q && !CYC_O && xact_q != 16'hFFFF) xact_d = xact_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_q          <= '0;
      tmo_q          <= '0;
      flags_q        <= '0;
      pulse_q        <= 1'b0;
      fv_q           <= 1'b0;
      fc_q           <= '0;
      xact_q         <= '0;
      err_seen_q     <= 1'b0;
      prev_valid_q   <= 1'b0;
      prev_cyc_q     <= 1'b0;
      prev_stb_q     <= 1'b0;
      prev_we_q      <= 1'b0;
      prev_stalled_q <= 1'b0;
      prev_adr_q     <= '0;
      prev_sel_q     <= '0;
      prev_dat_q     <= '0;
    end else begin
      out_q          <= out_d;
      tmo_q          <= tmo_d;
      flags_q        <= flags_d;
      pulse_q        <= |det;
      fv_q           <= fv_d;
      fc_q           <= fc_d;
      xact_q         <= xact_d;
      err_seen_q     <= err_seen_d;
      prev_valid_q   <= 1'b1;
      prev_cyc_q     <= CYC_O;
      prev_stb_q     <= STB_O;
      prev_we_q      <= WE_O;
      prev_stalled_q <= stalled;
      prev_adr_q     <= ADR_O;
      prev_sel_q     <= SEL_O;
      prev_dat_q     <= DAT_O;
    end
  end

  assign viol_flags  = flags_q;
  assign viol_pulse  = pulse_q;
  assign first_valid = fv_q;
  assign first_code  = fc_q;
  assign outstanding = out_q;
  assign xact_cnt    = xact_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_pipeline_checker.sv
// tb_wb_pipeline_checker: directed-vector bench for wb_pipeline_checker.
// Expected values are hand-derived from the protocol rules.
`default_nettype none

module tb_wb_pipeline_checker;

  localparam int TB_TIMEOUT = 12;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CYC_O = 1'b0, STB_O = 1'b0, WE_O = 1'b0;
  logic [31:0] ADR_O = '0, DAT_O = '0;
  logic [3:0]  SEL_O = '0;
  logic        STALL_I = 1'b0, ACK_I = 1'b0, ERR_I = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  viol_flags;
  logic        viol_pulse, first_valid;
  logic [2:0]  first_code;
  logic [3:0]  outstanding;
  logic [15:0] xact_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  wb_pipeline_checker #(
    .DATA_W(32), .ADR_W(32), .MAX_OUTSTANDING(8), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
    .ADR_O(ADR_O), .SEL_O(SEL_O), .DAT_O(DAT_O), .STALL_I(STALL_I),
    .ACK_I(ACK_I), .ERR_I(ERR_I), .clear(clear), .viol_flags(viol_flags),
    .viol_pulse(viol_pulse), .first_valid(first_valid), .first_code(first_code),
    .outstanding(outstanding), .xact_cnt(xact_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
  endtask

  // Drive one bus cycle, then sample just after the clock edge
  task automatic bus(input logic c, input logic s, input logic w, input logic [31:0] a,
                     input logic [3:0] sl, input logic [31:0] d,
                     input logic st, input logic ak, input logic er);
    CYC_O = c; STB_O = s; WE_O = w; ADR_O = a; SEL_O = sl; DAT_O = d;
    STALL_I = st; ACK_I = ak; ERR_I = er;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus(0, 0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    check("rst_flags", 32'(viol_flags), 32'h00);
    check("rst_pulse", 32'(viol_pulse), 32'h0);
    check("rst_first_valid", 32'(first_valid), 32'h0);
    check("rst_out", 32'(outstanding), 32'h0);
    check("rst_xact", 32'(xact_cnt), 32'h0);
    RST_N = 1'b1;
    idle();

    // Single read
    bus(1, 1, 0, 32'h100, 4'hF, 32'h0, 0, 0, 0);
    check("rd_out_req", 32'(outstanding), 32'h1);
    bus(1, 0, 0, 32'h0, 4'hF, 32'h0, 0, 1, 0);
    check("rd_out_ack", 32'(outstanding), 32'h0);
    idle();
    check("rd_xact", 32'(xact_cnt), 32'h1);
    check("rd_flags", 32'(viol_flags), 32'h00);

    // Eight writes, third one stalled for two cycles with everything held
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        bus(1, 1, 1, 32'h208, 4'hF, 32'hA002, 1, 0, 0);
        check("wr_stall_out", 32'(outstanding), 32'h2);
        bus(1, 1, 1, 32'h208, 4'hF, 32'hA002, 1, 0, 0);
      end
      bus(1, 1, 1, 32'h200 + 32'(4 * k), 4'hF, 32'hA000 + 32'(k), 0, 0, 0);
    end
    check("wr_peak_out", 32'(outstanding), 32'h8);
    for (int k = 0; k < 8; k++) bus(1, 0, 0, 32'h0, 4'hF, 32'h0, 0, 1, 0);
    check("wr_out_drained", 32'(outstanding), 32'h0);
    idle();
    check("wr_flags", 32'(viol_flags), 32'h00);
    check("wr_xact", 32'(xact_cnt), 32'h2);

    // Address changes while stalled
    bus(1, 1, 0, 32'h10, 4'hF, 32'h0, 1, 0, 0);
    check("stl_pulse_pre", 32'(viol_pulse), 32'h0);
    bus(1, 1, 0, 32'h14, 4'hF, 32'h0, 1, 0, 0);
    check("stl_flags", 32'(viol_flags), 32'h02);
    check("stl_pulse", 32'(viol_pulse), 32'h1);
    bus(1, 1, 0, 32'h14, 4'hF, 32'h0, 0, 0, 0);
    check("stl_pulse_drop", 32'(viol_pulse), 32'h0);
    check("stl_first_valid", 32'(first_valid), 32'h1);
    check("stl_first_code", 32'(first_code), 32'h1);
    bus(1, 0, 0, 32'h0, 4'hF, 32'h0, 0, 1, 0);
    idle();
    check("stl_flags_sticky", 32'(viol_flags), 32'h02);
    clear = 1'b1;
    idle();
    clear = 1'b0;
    check("clr_flags", 32'(viol_flags), 32'h00);
    check("clr_first_valid", 32'(first_valid), 32'h0);

    // Unsolicited ACK, then ACK and ERR together
    bus(1, 0, 0, 32'h0, 4'hF, 32'h0, 0, 0, 0);
    check("ack0_quiet", 32'(viol_flags), 32'h00);
    bus(1, 0, 0, 32'h0, 4'hF, 32'h0, 0, 1, 0);
    check("ack0_flags", 32'(viol_flags), 32'h08);
    bus(1, 0, 0, 32'h0, 4'hF, 32'h0, 0, 1, 1);
    check("ackerr_flags", 32'(viol_flags), 32'h18);
    check("ackerr_code", 32'(first_code), 32'h3);
    idle();
    check("ackerr_xact", 32'(xact_cnt), 32'h4);
    clear = 1'b1;
    idle();
    clear = 1'b0;

    // Timeout, then abort with a request outstanding
    bus(1, 1, 0, 32'h300, 4'hF, 32'h0, 0, 0, 0);
    for (int i = 1; i < TB_TIMEOUT; i++) bus(1, 0, 0, 32'h0, 4'hF, 32'h0, 0, 0, 0);
    check("tmo_not_yet", 32'(viol_flags), 32'h00);
    bus(1, 0, 0, 32'h0, 4'hF, 32'h0, 0, 0, 0);
    check("tmo_flags", 32'(viol_flags), 32'h80);
    check("tmo_pulse", 32'(viol_pulse), 32'h1);
    bus(1, 0, 0, 32'h0, 4'hF, 32'h0, 0, 0, 0);
    check("tmo_once", 32'(viol_pulse), 32'h0);
    idle();
    check("abort_flags", 32'(viol_flags), 32'hA0);
    check("abort_code", 32'(first_code), 32'h7);
    clear = 1'b1;
    idle();
    clear = 1'b0;

    // Write with no byte selects, then a clear that coincides with STB outside CYC
    bus(1, 1, 1, 32'h400, 4'h0, 32'h55, 0, 0, 0);
    check("sel0_flags", 32'(viol_flags), 32'h04);
    check("sel0_code", 32'(first_code), 32'h2);
    bus(1, 0, 0, 32'h0, 4'hF, 32'h0, 0, 1, 0);
    clear = 1'b1;
    bus(0, 1, 0, 32'h0, 4'hF, 32'h0, 0, 0, 0);
    clear = 1'b0;
    check("clrdet_flags", 32'(viol_flags), 32'h01);
    check("clrdet_valid", 32'(first_valid), 32'h1);
    check("clrdet_code", 32'(first_code), 32'h0);
    clear = 1'b1;
    idle();
    clear = 1'b0;

    // Overflow, then ERR termination and a legal abort after ERR
    for (int k = 0; k < 9; k++) bus(1, 1, 0, 32'h500 + 32'(4 * k), 4'hF, 32'h0, 0, 0, 0);
    check("ovf_flags", 32'(viol_flags), 32'h40);
    check("ovf_out_sat", 32'(outstanding), 32'h8);
    check("ovf_code", 32'(first_code), 32'h6);
    bus(1, 0, 0, 32'h0, 4'hF, 32'h0, 0, 0, 1);
    check("err_out_dec", 32'(outstanding), 32'h7);
    idle();
    check("err_abort_ok", 32'(viol_flags), 32'h40);
    check("err_xact", 32'(xact_cnt), 32'h7);
    check("err_out_idle", 32'(outstanding), 32'h0);

    // Asynchronous reset in the middle of a burst
    for (int k = 0; k < 3; k++) bus(1, 1, 0, 32'h600 + 32'(4 * k), 4'hF, 32'h0, 0, 0, 0);
    check("mid_out", 32'(outstanding), 32'h3);
    #2 RST_N = 1'b0;
    #1;
    check("mid_rst_out", 32'(outstanding), 32'h0);
    check("mid_rst_flags", 32'(viol_flags), 32'h00);
    check("mid_rst_xact", 32'(xact_cnt), 32'h0);
    check("mid_rst_valid", 32'(first_valid), 32'h0);
    bus(1, 0, 0, 32'h0, 4'hF, 32'h0, 0, 1, 0);
    RST_N = 1'b1;
    bus(1, 0, 0, 32'h0, 4'hF, 32'h0, 0, 1, 0);
    check("post_rst_flags", 32'(viol_flags), 32'h00);
    check("post_rst_pulse", 32'(viol_pulse), 32'h0);
    idle();
    check("post_rst_xact", 32'(xact_cnt), 32'h1);
    check("post_rst_quiet", 32'(viol_flags), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
